// File: rtl/fcmp_if.sv
// fcmp_if: issue-side and writeback-side handshake bundle for the FP compare/min-max unit
interface fcmp_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_x1;
  logic [W-1:0]     in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_nv;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_nv, out_tag
  );
  modport slave (
    input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_nv, out_tag
  );
endinterface

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: 2-stage valid/ready FP compare (FEQ/FLT/FLE) and FMIN/FMAX with NaN handling and tag passthrough
module fcmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input logic   clk,
  input logic   rst,
  fcmp_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, s2_free;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q, out_tag_q;
  logic [W-1:0]     s1_a_q, s1_b_q, out_data_q, out_data_d, mm;
  logic [1:0]       s1_nan_q, s1_nan_d, s1_snan_q, s1_snan_d;
  logic             s1_bz_q, s1_bz_d, s1_lt_q, s1_lt_d, s1_eq_q, s1_eq_d;
  logic             out_nv_q, out_nv_d, sa, sb, lt, eq, sel_a, r;

  function automatic logic is_nan(input logic [W-1:0] v);
    return (&v[W-2:MAN_W]) && (|v[MAN_W-1:0]);
  endfunction

  assign s2_free     = !out_valid_q || io.out_ready;
  assign io.in_ready = !s1_valid_q || s2_free;
  assign s1_valid_d  = io.in_ready ? io.in_valid : s1_valid_q;
  assign out_valid_d = s2_free ? s1_valid_q : out_valid_q;

  always_comb begin
    s1_nan_d  = {is_nan(io.in_x2), is_nan(io.in_x1)};
    s1_snan_d = s1_nan_d & ~{io.in_x2[MAN_W-1], io.in_x1[MAN_W-1]};
    s1_bz_d   = ~|io.in_x1[W-2:0] && ~|io.in_x2[W-2:0];
    s1_lt_d   = io.in_x1[W-2:0] < io.in_x2[W-2:0];
    s1_eq_d   = io.in_x1[W-2:0] == io.in_x2[W-2:0];
  end

  always_comb begin
    sa    = s1_a_q[W-1];
    sb    = s1_b_q[W-1];
    lt    = (sa == sb) ? (sa ? !s1_lt_q && !s1_eq_q : s1_lt_q) : (sa && !s1_bz_q);
    eq    = (s1_eq_q && sa == sb) || s1_bz_q;
    // selection order additionally ranks -0 below +0
    sel_a = lt || (s1_bz_q && sa && !sb);
    r     = !(|s1_nan_q) && (s1_op_q == 3'd0 ? eq : s1_op_q == 3'd1 ? lt : lt || eq);
    mm    = (&s1_nan_q) ? QNAN : s1_nan_q[0] ? s1_b_q : s1_nan_q[1] ? s1_a_q :
            (sel_a ^ (s1_op_q == 3'd4)) ? s1_a_q : s1_b_q;
    out_data_d = s1_op_q > 3'd4 ? '0 : s1_op_q > 3'd2 ? mm : {{(W-1){1'b0}}, r};
    out_nv_d   = s1_op_q > 3'd4 ? 1'b1 :
                 (s1_op_q == 3'd1 || s1_op_q == 3'd2) ? |s1_nan_q : |s1_snan_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_nan_q    <= '0;
      s1_snan_q   <= '0;
      s1_bz_q     <= 1'b0;
      s1_lt_q     <= 1'b0;
      s1_eq_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nv_q    <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (io.in_valid && io.in_ready) begin
        s1_op_q   <= io.in_op;
        s1_tag_q  <= io.in_tag;
        s1_a_q    <= io.in_x1;
        s1_b_q    <= io.in_x2;
        s1_nan_q  <= s1_nan_d;
        s1_snan_q <= s1_snan_d;
        s1_bz_q   <= s1_bz_d;
        s1_lt_q   <= s1_lt_d;
        s1_eq_q   <= s1_eq_d;
      end
      if (s2_free && s1_valid_q) begin
        out_data_q <= out_data_d;
        out_nv_q   <= out_nv_d;
        out_tag_q  <= s1_tag_q;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_nv    = out_nv_q;
  assign io.out_tag   = out_tag_q;
endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: random + directed checks of fcmp_pipe against an ordering-key reference model
module tb_fcmp_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcmp_if f ();
  fcmp_if #(.EXP_W(11), .MAN_W(52)) g ();
  fcmp_pipe dut (.clk(clk), .rst(rst), .io(f));
  fcmp_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (.clk(clk), .rst(rst), .io(g));

  typedef struct {
    logic [31:0] d;
    logic        nv;
    logic [4:0]  t;
    logic        fx;
    logic [31:0] fd;
    logic        fnv;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          bp_mode = 0;
  logic        fix_en = 1'b0;
  logic [31:0] fix_d = '0;
  logic        fix_nv = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hd;
  logic        hnv;
  logic [4:0]  ht;
  logic [31:0] md;
  logic        mnv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // IEEE ordering via signed magnitude key: -0 and +0 collapse to key 0
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic nv);
    logic  na, nb, sna, snb;
    longint ka, kb;
    na  = a[30:23] == 8'hff && a[22:0] != 0;
    nb  = b[30:23] == 8'hff && b[22:0] != 0;
    sna = na && !a[22];
    snb = nb && !b[22];
    ka  = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb  = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    d   = 32'd0;
    nv  = 1'b0;
    case (op)
      3'd0: begin d[0] = !(na || nb) && ka == kb; nv = sna || snb; end
      3'd1: begin d[0] = !(na || nb) && ka < kb;  nv = na || nb; end
      3'd2: begin d[0] = !(na || nb) && ka <= kb; nv = na || nb; end
      3'd3, 3'd4: begin
        nv = sna || snb;
        if (na && nb) d = 32'h7fc00000;
        else if (na) d = b;
        else if (nb) d = a;
        else if (ka != kb) d = ((ka < kb) == (op == 3'd3)) ? a : b;
        else d = (a[31] == (op == 3'd3)) ? a : b;
      end
      default: nv = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 11))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h3f800000;
      3: return 32'hbf800000;
      4: return 32'h7fc00000;
      5: return 32'h7f800001;
      6: return 32'hff800000;
      7: return 32'h7f800000;
      8: return $urandom & 32'h807fffff;
      9: return 32'hffc00005;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    f.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      f.out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold <= 1'b0;
    end else begin
      if (hold) begin
        chk("hold_data", f.out_data, hd);
        chk("hold_nv", f.out_nv, hnv);
        chk("hold_tag", f.out_tag, ht);
      end
      if (f.out_valid && f.out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("data", f.out_data, e.d);
          chk("nv", f.out_nv, e.nv);
          chk("tag", f.out_tag, e.t);
          if (e.fx) begin
            chk("spec_data", f.out_data, e.fd);
            chk("spec_nv", f.out_nv, e.fnv);
          end
        end
      end
      if (f.in_valid && f.in_ready) begin
        model(f.in_op, f.in_x1, f.in_x2, md, mnv);
        sb.push_back('{md, mnv, f.in_tag, fix_en, fix_d, fix_nv});
      end
      hold <= f.out_valid && !f.out_ready;
      hd   <= f.out_data;
      hnv  <= f.out_nv;
      ht   <= f.out_tag;
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic fx, input logic [31:0] fd, input logic fnv);
    bit done = 0;
    f.in_valid = 1'b1;
    f.in_op = op;
    f.in_x1 = a;
    f.in_x2 = b;
    f.in_tag = t;
    fix_en = fx;
    fix_d = fd;
    fix_nv = fnv;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = f.in_ready;
      @(posedge clk);
      #1;
    end
    f.in_valid = 1'b0;
    fix_en = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_left", 64'(sb.size()), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, idx;
    logic [31:0] a, b;
    f.in_valid = 1'b0; f.in_op = '0; f.in_x1 = '0; f.in_x2 = '0; f.in_tag = '0;
    g.in_valid = 1'b0; g.in_op = '0; g.in_x1 = '0; g.in_x2 = '0; g.in_tag = '0;
    g.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", f.out_valid, 0);
    chk("rst_out_data", f.out_data, 0);
    chk("rst_out_nv", f.out_nv, 0);
    chk("rst_out_tag", f.out_tag, 0);
    chk("rst_in_ready", f.in_ready, 1);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // back-to-back FLT/FLE/FEQ of -1.0 vs 1.0, cycle-exact
    f.in_valid = 1'b1; f.in_x1 = 32'hbf800000; f.in_x2 = 32'h3f800000;
    f.in_op = 3'd1; f.in_tag = 5'd1;
    @(negedge clk); chk("lat_c0_valid", f.out_valid, 0);
    cycle(); f.in_op = 3'd2; f.in_tag = 5'd2;
    @(negedge clk); chk("lat_c1_valid", f.out_valid, 0);
    cycle(); f.in_op = 3'd0; f.in_tag = 5'd3;
    @(negedge clk);
    chk("lat_c2_valid", f.out_valid, 1);
    chk("lat_flt", {f.out_data, f.out_tag, f.out_nv}, {32'd1, 5'd1, 1'b0});
    cycle(); f.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_fle", {f.out_valid, f.out_data, f.out_tag, f.out_nv}, {1'b1, 32'd1, 5'd2, 1'b0});
    cycle();
    @(negedge clk);
    chk("lat_feq", {f.out_valid, f.out_data, f.out_tag, f.out_nv}, {1'b1, 32'd0, 5'd3, 1'b0});
    cycle();
    @(negedge clk); chk("lat_idle", f.out_valid, 0);
    drain();

    // signed zeros, NaNs, illegal op
    send(3'd0, 32'h80000000, 32'h00000000, 5'd4, 1, 32'd1, 0);
    send(3'd1, 32'h80000000, 32'h00000000, 5'd5, 1, 32'd0, 0);
    send(3'd3, 32'h80000000, 32'h00000000, 5'd6, 1, 32'h80000000, 0);
    send(3'd4, 32'h80000000, 32'h00000000, 5'd7, 1, 32'h00000000, 0);
    send(3'd3, 32'h00000000, 32'h80000000, 5'd8, 1, 32'h80000000, 0);
    send(3'd1, 32'h7fc00000, 32'h3f800000, 5'd9, 1, 32'd0, 1);
    send(3'd0, 32'h7fc00000, 32'h3f800000, 5'd10, 1, 32'd0, 0);
    send(3'd0, 32'h7f800001, 32'h00000000, 5'd11, 1, 32'd0, 1);
    send(3'd3, 32'h7fc00000, 32'h40000000, 5'd12, 1, 32'h40000000, 0);
    send(3'd4, 32'h7f800001, 32'h7fc00001, 5'd13, 1, 32'h7fc00000, 1);
    send(3'd7, 32'h3f800000, 32'h40000000, 5'd14, 1, 32'd0, 1);
    send(3'd5, 32'h7f800001, 32'h40000000, 5'd15, 1, 32'd0, 1);
    drain();

    // backpressure: 5 stalled cycles offering 4 ops
    bp_mode = 1;
    repeat (2) cycle();
    acc = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      f.in_valid = idx < 4; f.in_op = 3'd1;
      f.in_x1 = 32'h3f800000 + 32'(idx); f.in_x2 = 32'h3f800002; f.in_tag = 5'(16 + idx);
      @(negedge clk);
      if (f.in_valid && f.in_ready) begin acc++; idx++; end
      cycle();
    end
    chk("bp_accepted", 64'(acc), 2);
    @(negedge clk); chk("bp_in_ready", f.in_ready, 0);
    chk("bp_out_tag", f.out_tag, 16);
    bp_mode = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      f.in_valid = 1'b1; f.in_x1 = 32'h3f800000 + 32'(idx); f.in_tag = 5'(16 + idx);
      @(negedge clk);
      if (f.in_ready) idx++;
      cycle();
    end
    f.in_valid = 1'b0;
    chk("bp_all_sent", 64'(idx), 4);
    drain();

    // reset with two ops in flight
    send(3'd1, 32'hbf800000, 32'h3f800000, 5'd21, 0, 0, 0);
    send(3'd2, 32'hbf800000, 32'h3f800000, 5'd22, 0, 0, 0);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_mid_out", {f.out_valid, f.out_data, f.out_nv, f.out_tag, f.in_ready},
          {1'b1 == 1'b0, 32'd0, 1'b0, 5'd0, 1'b1});
    end

    // 64-bit instance: -2.0 vs -3.0
    cycle();
    g.in_valid = 1'b1; g.in_op = 3'd1; g.in_tag = 5'd1;
    g.in_x1 = 64'hc000000000000000; g.in_x2 = 64'hc008000000000000;
    cycle(); g.in_op = 3'd4; g.in_tag = 5'd2;
    cycle(); g.in_valid = 1'b0;
    @(negedge clk);
    chk("d64_flt_valid", g.out_valid, 1);
    chk("d64_flt", g.out_data, 64'd0);
    chk("d64_flt_tag", {g.out_tag, g.out_nv}, {5'd1, 1'b0});
    cycle();
    @(negedge clk);
    chk("d64_fmax", g.out_data, 64'hc000000000000000);
    chk("d64_fmax_tag", {g.out_valid, g.out_tag, g.out_nv}, {1'b1, 5'd2, 1'b0});

    // random stream with random backpressure
    bp_mode = 2;
    for (int n = 0; n < 400; n++) begin
      a = rnd_val();
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = a ^ 32'h80000000;
        2: b = a + 32'($urandom_range(0, 2));
        default: b = rnd_val();
      endcase
      if ($urandom_range(0, 1) != 0) cycle();
      send(3'($urandom_range(0, 9) > 7 ? $urandom_range(5, 7) : $urandom_range(0, 4)),
           a, b, 5'($urandom), 0, 0, 0);
    end
    bp_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
- Parametrised, pipelined floating-point compare/min-max unit for the FPU.
- Generalises the single-precision combinational less-than compare in four ways: configurable exponent/mantissa widths, five operations, IEEE NaN handling with an invalid flag, and a 2-stage valid/ready pipeline with tag passthrough.
- Sits between the FPU issue stage and writeback.

Parameters:
- EXP_W, 8, exponent width; total width W = 1+EXP_W+MAN_W.
- MAN_W, 23, mantissa width; bit MAN_W-1 is the quiet bit.
- TAG_W, 5, width of the opaque tag (e.g. destination register) carried alongside each operation.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts; a transfer occurs when in_valid && in_ready on a rising edge.
- in_op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX; 101-111 illegal.
- in_x1  in  W  operand 1.
- in_x2  in  W  operand 2.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_data  out  W  result.
- out_nv  out  1  invalid-operation flag.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset, asynchronous: both stage valids = 0; out_valid = 0, out_data = 0, out_nv = 0, out_tag = 0. in_ready = 1 after reset. Reset mid-operation discards all in-flight operations with no output.
- Stage 1 (registered on accept), per operand:
  - classify: NaN = exp all-ones and mantissa ≠ 0; sNaN = NaN with quiet bit 0; zero = bits[W-2:0] == 0.
  - compute unsigned magnitude lt/eq on bits[W-2:0].
  - register op, tag and both operands.
- Stage 2 (registered): result select; drives the out_* registers.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 per cycle with no backpressure.
- Flow control:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
  - Stalls hold all stage contents unchanged.
  - While out_valid && !out_ready, out_data, out_nv and out_tag are stable.
- Ordered less-than (a<b), with both zero treated as equal (+0 == −0):
  - signs 0/0: mag_lt.
  - 0/1: false.
  - 1/0: !bothzero.
  - 1/1: mag_gt.
- Compare ops (FEQ/FLT/FLE): result zero-extended to W, so out_data = {(W-1)'b0, r}.
  - FEQ: r = !anyNaN && (bit-equal || bothzero); nv = either operand is sNaN.
  - FLT: r = !anyNaN && a<b; nv = anyNaN (quiet or signalling).
  - FLE: r = !anyNaN && (a<b || equal); nv = anyNaN.
- FMIN/FMAX:
  - One NaN: return the other operand.
  - Both NaN: return canonical NaN = {0, all-ones exp, 1, zeros}; 0x7FC00000 at defaults.
  - −0 orders below +0 for selection: FMIN(+0,−0) = −0, FMAX(−0,+0) = +0.
  - Otherwise return the smaller (FMIN) or larger (FMAX) operand, bit-exact.
  - nv = either operand is sNaN.
- Illegal op: out_data = 0, out_nv = 1. The op still occupies one slot and produces an output.
- Tag emerges with its own result; results leave in issue order.

Test Plan:
- Reset asserted mid-stream with 2 ops in flight → no out_valid after release; all out_* = 0; in_ready = 1.
- Back-to-back FLT, FLE, FEQ with x1 = 0xBF800000 (−1.0), x2 = 0x3F800000 (1.0), tags 1, 2, 3 → out_data 1, 1, 0 on 3 consecutive cycles, first at accept+2, tags 1, 2, 3, nv = 0.
- FEQ and FLT with x1 = 0x80000000 (−0), x2 = 0x00000000 (+0) → FEQ = 1, FLT = 0. FMIN → 0x80000000; FMAX → 0x00000000.
- NaNs:
  - FLT(0x7FC00000, 0x3F800000) → 0, nv = 1.
  - FEQ with the same operands → 0, nv = 0.
  - FEQ(0x7F800001, 0x0) → 0, nv = 1.
  - FMIN(0x7FC00000, 0x40000000) → 0x40000000.
  - FMAX(0x7F800001, 0x7FC00001) → 0x7FC00000, nv = 1.
- Backpressure: out_ready = 0 for 5 cycles with 4 ops offered → exactly 2 accepted, then in_ready = 0. out_data and out_tag held constant. On release, all 4 results arrive in order, none lost or duplicated.
- Illegal op 3'b111 → out_data = 0, out_nv = 1. Rerun with EXP_W = 11, MAN_W = 52: FLT(−2.0, −3.0) → 0; FMAX(−2.0, −3.0) → 0xC000000000000000.
